// File: rtl/stereo_sample_queue.sv
// stereo_sample_queue
//
// Circular buffer holding the most recent DEPTH left/right sample pairs. Each
// accepted write that leaves the queue full triggers a replay burst that
// presents the whole window oldest-to-newest, one pair per clock, with
// `sequencing` high for exactly DEPTH cycles. The burst feeds a band FIR.
//
// Optional build macro: QUEUE_ZERO_PAD_EN
//   When defined, every accepted write starts a burst. Slots that do not hold
//   a stored pair yet read as 0/0, and the stored pairs follow oldest-first.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   wrt_smpl   one-cycle strobe, new pair on lft_smpl/rght_smpl
//   lft_smpl   signed left sample in
//   rght_smpl  signed right sample in
//   sequencing high while lft_out/rght_out carry a replay slot
//   lft_out    registered left sample of the current slot
//   rght_out   registered right sample of the current slot
//   full       queue holds DEPTH valid pairs
//   overrun    sticky, a strobe was dropped; cleared only by rst

module stereo_sample_queue #(
  parameter int unsigned DEPTH = 1021,
  parameter int unsigned AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrt_smpl,
  input  logic signed [15:0] lft_smpl,
  input  logic signed [15:0] rght_smpl,
  output logic               sequencing,
  output logic signed [15:0] lft_out,
  output logic signed [15:0] rght_out,
  output logic               full,
  output logic               overrun
);

  typedef enum logic [1:0] {StIdle, StPrime, StSeq} state_e;

  // Counters are one bit wider than pointers so they can hold DEPTH itself.
  localparam int unsigned   CW       = AW + 1;
  localparam logic [AW-1:0] LastPtr  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
  localparam logic [CW-1:0] LastSlot = CW'(DEPTH - 1);

  logic [31:0] mem [DEPTH];

  state_e               state_q;
  logic [AW-1:0]        new_ptr_q, old_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, rd_cnt_q;
  logic                 full_q, overrun_q, seq_q;
  logic                 pend_q;
  logic signed [15:0]   pend_lft_q, pend_rght_q;
  logic signed [15:0]   lft_q, rght_q;

  // Modulo-DEPTH increment; DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic          last_slot;
  logic          idle_like;
  logic          commit;
  logic [31:0]   commit_data;
  logic [AW-1:0] new_ptr_w, old_ptr_w;
  logic [CW-1:0] count_w;
  logic          post_full;
  logic          start_burst;
  logic          rd_issue;
  logic          pad;

  assign last_slot = (state_q == StSeq) && (rd_cnt_q == LastSlot);

  // The final SEQ cycle behaves like IDLE for writes, so a pending pair can be
  // committed on the same edge the burst ends.
  assign idle_like = (state_q == StIdle) || last_slot;

  assign commit      = idle_like && (pend_q || wrt_smpl);
  assign commit_data = pend_q ? {pend_lft_q, pend_rght_q} : {lft_smpl, rght_smpl};

  assign new_ptr_w = ptr_inc(new_ptr_q);
  assign old_ptr_w = (count_q == DepthCnt) ? ptr_inc(old_ptr_q) : old_ptr_q;
  assign count_w   = (count_q == DepthCnt) ? count_q : count_q + 1'b1;
  assign post_full = (count_w == DepthCnt);

  assign rd_issue = (state_q == StPrime) || ((state_q == StSeq) && !last_slot);

`ifdef QUEUE_ZERO_PAD_EN
  // Slot index being fetched this cycle; the first DEPTH-count slots are
  // padding. count_q is stable for the whole burst since writes wait.
  logic [CW-1:0] rd_slot;
  assign rd_slot     = (state_q == StPrime) ? '0 : rd_cnt_q + 1'b1;
  assign pad         = rd_slot < (DepthCnt - count_q);
  assign start_burst = commit;
`else
  assign pad         = 1'b0;
  assign start_burst = commit && post_full;
`endif

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[new_ptr_q] <= commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      new_ptr_q   <= '0;
      old_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_cnt_q    <= '0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      seq_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_lft_q  <= '0;
      pend_rght_q <= '0;
      lft_q       <= '0;
      rght_q      <= '0;
    end else begin
      // Pointer and occupancy update for a committed write.
      if (commit) begin
        new_ptr_q <= new_ptr_w;
        old_ptr_q <= old_ptr_w;
        count_q   <= count_w;
        full_q    <= post_full;
      end

      // Pending register: holds one strobe that arrives while busy.
      if (idle_like) begin
        if (pend_q) begin
          // Pending pair is committed now; a coincident strobe takes its place.
          pend_q <= wrt_smpl;
          if (wrt_smpl) begin
            pend_lft_q  <= lft_smpl;
            pend_rght_q <= rght_smpl;
          end
        end
      end else if (wrt_smpl) begin
        if (pend_q) begin
          overrun_q <= 1'b1;
        end else begin
          pend_q      <= 1'b1;
          pend_lft_q  <= lft_smpl;
          pend_rght_q <= rght_smpl;
        end
      end

      // Synchronous read straight into the output registers.
      if (rd_issue) begin
        if (pad) begin
          lft_q  <= '0;
          rght_q <= '0;
        end else begin
          lft_q    <= mem[rd_ptr_q][31:16];
          rght_q   <= mem[rd_ptr_q][15:0];
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start_burst) begin
            state_q  <= StPrime;
            rd_ptr_q <= old_ptr_w;
          end
        end
        StPrime: begin
          state_q  <= StSeq;
          seq_q    <= 1'b1;
          rd_cnt_q <= '0;
        end
        StSeq: begin
          if (last_slot) begin
            seq_q <= 1'b0;
            if (start_burst) begin
              state_q  <= StPrime;
              rd_ptr_q <= old_ptr_w;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          seq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sequencing = seq_q;
  assign lft_out    = lft_q;
  assign rght_out   = rght_q;
  assign full       = full_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_stereo_sample_queue.sv
// Directed self-checking bench for stereo_sample_queue with DEPTH=8.
// Covers reset, fill, wrap/overwrite, pending commit, overrun, reset
// mid-burst and the post-reset single write (zero-pad aware).

module tb_stereo_sample_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wrt_smpl = 1'b0;
  logic signed [15:0] lft_smpl = '0;
  logic signed [15:0] rght_smpl = '0;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic               full;
  logic               overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [15:0] bl [16];
  logic signed [15:0] br [16];
  int n_got;
  int lat;
  int timeout;

  stereo_sample_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrt_smpl   (wrt_smpl),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .sequencing (sequencing),
    .lft_out    (lft_out),
    .rght_out   (rght_out),
    .full       (full),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input int l);
    wrt_smpl  = 1'b1;
    lft_smpl  = 16'(l);
    rght_smpl = 16'(-l);
    tick();
    wrt_smpl  = 1'b0;
  endtask

  // Waits (bounded) for a burst and records it. Optional strobes are driven
  // at the given sample indices of the burst (-1 = none).
  task automatic collect_burst(input int inj_a, input int la, input int inj_b, input int lb);
    n_got   = 0;
    lat     = 0;
    timeout = 0;
    while (sequencing !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (sequencing !== 1'b1) begin
      timeout = 1;
      return;
    end
    while (sequencing === 1'b1 && n_got < 16) begin
      bl[n_got] = lft_out;
      br[n_got] = rght_out;
      if (n_got == inj_a) begin
        wrt_smpl = 1'b1; lft_smpl = 16'(la); rght_smpl = 16'(-la);
      end else if (n_got == inj_b) begin
        wrt_smpl = 1'b1; lft_smpl = 16'(lb); rght_smpl = 16'(-lb);
      end else begin
        wrt_smpl = 1'b0;
      end
      n_got++;
      tick();
    end
    wrt_smpl = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (sequencing !== 1'b0) begin n_fail++; $display("FAIL reset_seq got %b want 0", sequencing); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_cmp++; if (lft_out !== 16'sd0) begin n_fail++; $display("FAIL reset_lft got %0d want 0", lft_out); end
    n_cmp++; if (rght_out !== 16'sd0) begin n_fail++; $display("FAIL reset_rght got %0d want 0", rght_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int v = 1; v <= 7; v++) begin
      write_pair(v);
      tick();
      n_cmp++; if (sequencing !== 1'b0 || full !== 1'b0) begin
        n_fail++; $display("FAIL fill_idle_%0d got seq=%b full=%b want 0 0", v, sequencing, full);
      end
    end
    write_pair(8);
    n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
    n_cmp++; if (sequencing !== 1'b0) begin n_fail++; $display("FAIL fill_prime_seq got %b want 0", sequencing); end
    collect_burst(-1, 0, -1, 0);
    n_cmp++; if (timeout != 0) begin n_fail++; $display("FAIL fill_timeout got timeout want burst"); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL fill_latency got %0d want 1", lat); end
    n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL fill_len got %0d want 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(i + 1) || br[i] !== 16'(-(i + 1))) begin
        n_fail++; $display("FAIL fill_slot%0d got %0d/%0d want %0d/%0d", i, bl[i], br[i], i + 1, -(i + 1));
      end
    end
    n_cmp++; if (sequencing !== 1'b0) begin n_fail++; $display("FAIL fill_end_seq got %b want 0", sequencing); end
    tick();
    n_cmp++; if (lft_out !== 16'sd8) begin n_fail++; $display("FAIL fill_hold got %0d want 8", lft_out); end
  endtask

  task automatic test_wrap();
    write_pair(9);
    collect_burst(-1, 0, -1, 0);
    n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL wrap9_len got %0d want 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(i + 2)) begin
        n_fail++; $display("FAIL wrap9_slot%0d got %0d want %0d", i, bl[i], i + 2);
      end
    end
    for (int v = 10; v <= 16; v++) begin
      tick();
      write_pair(v);
      collect_burst(-1, 0, -1, 0);
      n_cmp++; if (n_got != 8 || bl[0] !== 16'(v - 7) || bl[7] !== 16'(v)) begin
        n_fail++; $display("FAIL wrap%0d_ends got n=%0d %0d..%0d want 8 %0d..%0d",
                           v, n_got, bl[0], bl[7], v - 7, v);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(i + 9) || br[i] !== 16'(-(i + 9))) begin
        n_fail++; $display("FAIL wrap16_slot%0d got %0d/%0d want %0d", i, bl[i], br[i], i + 9);
      end
    end
  endtask

  task automatic test_pending();
    int exp_l [8];
    tick();
    write_pair(17);
    collect_burst(3, 20, -1, 0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(i + 10)) begin
        n_fail++; $display("FAIL pend_cur_slot%0d got %0d want %0d", i, bl[i], i + 10);
      end
    end
    collect_burst(-1, 0, -1, 0);
    exp_l = '{11, 12, 13, 14, 15, 16, 17, 20};
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL pend_gap got %0d want 1", lat); end
    n_cmp++; if (n_got != 8) begin n_fail++; $display("FAIL pend_len got %0d want 8", n_got); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(exp_l[i]) || br[i] !== 16'(-exp_l[i])) begin
        n_fail++; $display("FAIL pend_slot%0d got %0d/%0d want %0d", i, bl[i], br[i], exp_l[i]);
      end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL pend_overrun got %b want 0", overrun); end
  endtask

  task automatic test_overrun();
    int exp_a [8];
    int exp_b [8];
    int highs;
    tick();
    write_pair(21);
    collect_burst(2, 30, 5, 31);
    exp_a = '{12, 13, 14, 15, 16, 17, 20, 21};
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(exp_a[i])) begin
        n_fail++; $display("FAIL ovr_cur_slot%0d got %0d want %0d", i, bl[i], exp_a[i]);
      end
    end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
    collect_burst(-1, 0, -1, 0);
    exp_b = '{13, 14, 15, 16, 17, 20, 21, 30};
    n_cmp++; if (lat != 1 || n_got != 8) begin
      n_fail++; $display("FAIL ovr_next got gap=%0d n=%0d want 1 8", lat, n_got);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bl[i] !== 16'(exp_b[i])) begin
        n_fail++; $display("FAIL ovr_next_slot%0d got %0d want %0d", i, bl[i], exp_b[i]);
      end
    end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sequencing === 1'b1) highs++;
    end
    n_cmp++; if (highs != 0) begin n_fail++; $display("FAIL ovr_no_third got %0d want 0", highs); end
    n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_reset_mid();
    int idx;
    int waitc;
    int highs;
    write_pair(40);
    waitc = 0;
    while (sequencing !== 1'b1 && waitc < 40) begin
      tick();
      waitc++;
    end
    n_cmp++; if (sequencing !== 1'b1) begin n_fail++; $display("FAIL rmid_start got %b want 1", sequencing); end
    idx = 0;
    while (sequencing === 1'b1 && idx < 4) begin
      wrt_smpl = (idx == 2); lft_smpl = 16'sd50; rght_smpl = -16'sd50;
      tick();
      idx++;
    end
    wrt_smpl = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++; if (sequencing !== 1'b0) begin n_fail++; $display("FAIL rmid_seq got %b want 0", sequencing); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL rmid_full got %b want 0", full); end
    n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun got %b want 0", overrun); end
    n_cmp++; if (lft_out !== 16'sd0) begin n_fail++; $display("FAIL rmid_lft got %0d want 0", lft_out); end
    rst = 1'b0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sequencing === 1'b1) highs++;
    end
    n_cmp++; if (highs != 0) begin n_fail++; $display("FAIL rmid_pend_dropped got %0d want 0", highs); end
  endtask

  task automatic test_zero_pad();
    int highs;
    write_pair(5);
`ifdef QUEUE_ZERO_PAD_EN
    collect_burst(-1, 0, -1, 0);
    n_cmp++; if (lat != 1 || n_got != 8) begin
      n_fail++; $display("FAIL zpad_burst got gap=%0d n=%0d want 1 8", lat, n_got);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (bl[i] !== 16'sd0 || br[i] !== 16'sd0) begin
        n_fail++; $display("FAIL zpad_slot%0d got %0d/%0d want 0/0", i, bl[i], br[i]);
      end
    end
    n_cmp++; if (bl[7] !== 16'sd5 || br[7] !== -16'sd5) begin
      n_fail++; $display("FAIL zpad_last got %0d/%0d want 5/-5", bl[7], br[7]);
    end
`else
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sequencing === 1'b1) highs++;
    end
    n_cmp++; if (highs != 0) begin n_fail++; $display("FAIL single_no_seq got %0d want 0", highs); end
`endif
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL single_full got %b want 0", full); end
  endtask

  initial begin
    test_reset();
`ifndef QUEUE_ZERO_PAD_EN
    test_fill();
    test_wrap();
    test_pending();
    test_overrun();
    test_reset_mid();
`endif
    test_zero_pad();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
